bht_scheduler: RTL

Branch history table (BHT) of 2-bit saturating counters plus the scheduler that sequences access to it. The table has a single access port per cycle. Two requesters share it: the fetch-side predictor, which issues lookups, and the ROB, which sends resolution updates. The block runs a post-reset initialisation sweep, gives lookups priority, and buffers ROB updates in a small FIFO that is forced to drain when full.

---
 rtl/bht_scheduler.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/bht_scheduler.sv
// Branch history table of 2-bit saturating counters with a lookup-priority access
// scheduler, post-reset init sweep and a ROB update FIFO. Optional perf counters: BHT_PERF_EN.
module bht_scheduler #(
    parameter int INDEX_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               lookup_valid,
    input  logic [31:0]        lookup_pc,
    output logic               lookup_ready,
    output logic               lookup_resp_valid,
    output logic               lookup_taken,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    output logic               upd_ready,
    output logic               init_done
`ifdef BHT_PERF_EN
    ,
    output logic [31:0]        perf_lookups,
    output logic [31:0]        perf_lookup_stalls
`endif
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [INDEX_W-1:0] INIT_LAST = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state_reg, state_next;
    logic [INDEX_W-1:0] init_idx_reg, init_idx_next;

    logic [1:0]         bht_mem [ENTRIES];
    logic               tbl_we;
    logic [INDEX_W-1:0] tbl_waddr;
    logic [1:0]         tbl_wdata;

    logic [INDEX_W:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               run;
    logic               fifo_full;
    logic               fifo_empty;
    logic               lookup_fire;
    logic               enq;
    logic               deq;
    logic [INDEX_W-1:0] lookup_idx;
    logic [INDEX_W:0]   head_entry;
    logic [INDEX_W-1:0] head_idx;
    logic               head_taken;
    logic [1:0]         head_ctr;
    logic [1:0]         ctr_updated;

    logic               lookup_resp_valid_reg;
    logic               lookup_taken_reg;

    logic               unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_W+2], lookup_pc[1:0]};

    // ---------------- scheduler decisions ----------------
    assign run          = (state_reg == ST_RUN);
    assign fifo_full    = (count_reg == FULL_CNT);
    assign fifo_empty   = (count_reg == '0);
    assign lookup_ready = run && !fifo_full;
    assign upd_ready    = run && !fifo_full;
    assign init_done    = run;

    assign lookup_idx  = lookup_pc[INDEX_W+1:2];
    assign lookup_fire = rdy && lookup_valid && lookup_ready;
    assign enq         = rdy && upd_valid && upd_ready;
    // A full FIFO pre-empts lookups; otherwise drains only use idle slots.
    assign deq         = rdy && run && (fifo_full || (!lookup_valid && !fifo_empty));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_INIT;
            init_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_idx_reg <= init_idx_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_idx_next = init_idx_reg;
        case (state_reg)
            ST_INIT: begin
                if (rdy) begin
                    if (init_idx_reg == INIT_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        init_idx_next = init_idx_reg + INDEX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // ---------------- update FIFO ----------------
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            logic [INDEX_W:0] entry_reg;
            always_ff @(posedge clk) begin
                if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= {upd_taken, upd_index};
                end
            end
            assign fifo_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- drain: read-modify-write of head counter ----------------
    assign head_entry = fifo_q[rd_ptr_reg];
    assign head_idx   = head_entry[INDEX_W-1:0];
    assign head_taken = head_entry[INDEX_W];
    assign head_ctr   = bht_mem[head_idx];

    always_comb begin
        ctr_updated = head_ctr;
        if (head_taken) begin
            if (head_ctr != 2'b11) begin
                ctr_updated = head_ctr + 2'd1;
            end
        end else begin
            if (head_ctr != 2'b00) begin
                ctr_updated = head_ctr - 2'd1;
            end
        end
    end

    // ---------------- table write port ----------------
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = '0;
        tbl_wdata = 2'b00;
        if (state_reg == ST_INIT && rdy) begin
            tbl_we    = 1'b1;
            tbl_waddr = init_idx_reg;
            tbl_wdata = 2'b01;
        end else if (deq) begin
            tbl_we    = 1'b1;
            tbl_waddr = head_idx;
            tbl_wdata = ctr_updated;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            bht_mem[tbl_waddr] <= tbl_wdata;
        end
    end

    // ---------------- lookup response (registered read) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookup_resp_valid_reg <= 1'b0;
            lookup_taken_reg      <= 1'b0;
        end else if (rdy) begin
            lookup_resp_valid_reg <= lookup_fire;
            if (lookup_fire) begin
                lookup_taken_reg <= bht_mem[lookup_idx][1];
            end
        end
    end

    assign lookup_resp_valid = lookup_resp_valid_reg;
    assign lookup_taken      = lookup_taken_reg;

`ifdef BHT_PERF_EN
    logic [31:0] perf_lookups_reg;
    logic [31:0] perf_lookup_stalls_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lookups_reg       <= '0;
            perf_lookup_stalls_reg <= '0;
        end else if (rdy && run) begin
            if (lookup_fire) begin
                perf_lookups_reg <= perf_lookups_reg + 32'd1;
            end
            if (lookup_valid && !lookup_ready) begin
                perf_lookup_stalls_reg <= perf_lookup_stalls_reg + 32'd1;
            end
        end
    end

    assign perf_lookups       = perf_lookups_reg;
    assign perf_lookup_stalls = perf_lookup_stalls_reg;
`endif

endmodule
